udp_rx_parser: RTL and testbench
================================

# udp_rx_parser

Receive-side UDP stage. It sits directly downstream of the IP receive output of the Ethernet/IP stack and consumes its IP header and payload stream. It keeps only datagrams with protocol 17 addressed to the configured local port, strips the 8-byte UDP header and presents header fields plus a length-trimmed payload stream to the RTPS/application logic. Everything else is discarded.

## Interface
- `PORT_MATCH_EN`, default 1: when 1, datagrams whose destination port differs from `local_port` are dropped. When 0, every UDP datagram is forwarded.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high. Ports are `clk` and `rst`.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_ip_hdr_valid`  in  1  IP header valid.
- `s_ip_hdr_ready`  out  1  IP header accept.
- `s_ip_length`  in  16  IP total length.
- `s_ip_protocol`  in  8  IP protocol.
- `s_ip_source_ip`  in  32  source address.
- `s_ip_dest_ip`  in  32  destination address.
- `s_ip_payload_axis_tdata`  in  8  IP payload byte.
- `s_ip_payload_axis_tvalid`  in  1  input beat valid.
- `s_ip_payload_axis_tready`  out  1  input beat accept.
- `s_ip_payload_axis_tlast`  in  1  last byte of the IP payload.
- `s_ip_payload_axis_tuser`  in  1  upstream error flag.
- `local_port`  in  16  port filter value; must be static while `s_ip_hdr_ready` is low.
- `m_udp_hdr_valid`  out  1  UDP header valid.
- `m_udp_hdr_ready`  in  1  UDP header accept.
- `m_udp_source_ip`  out  32  latched source address.
- `m_udp_dest_ip`  out  32  latched destination address.
- `m_udp_source_port`  out  16  UDP source port.
- `m_udp_dest_port`  out  16  UDP destination port.
- `m_udp_length`  out  16  UDP length field, header included.
- `m_udp_payload_axis_tdata`  out  8  payload byte.
- `m_udp_payload_axis_tvalid`  out  1  payload beat valid.
- `m_udp_payload_axis_tready`  in  1  payload beat accept.
- `m_udp_payload_axis_tlast`  out  1  last payload byte.
- `m_udp_payload_axis_tuser`  out  1  payload error flag.
- `error_early_termination`  out  1  one-cycle pulse when the IP stream ends before the UDP data does.
- `drop`  out  1  one-cycle pulse on every discarded datagram.

## Operation
States: IDLE, HEADER, PAYLOAD, DROP.

**IDLE**
- `s_ip_hdr_ready` = 1.
- On header handshake, latch the IP addresses.
- If protocol = 17, go to HEADER with byte counter = 0. Otherwise pulse `drop` and go to DROP.

**HEADER**
- `s_ip_payload_axis_tready` = 1.
- Bytes are captured big-endian: 0–1 source port, 2–3 destination port, 4–5 length, 6–7 checksum (ignored).
- tlast on bytes 0–6: pulse `error_early_termination` and `drop`, go to IDLE.
- On byte 7, check in priority order:
  - byte 7 has tlast: drop (zero-payload datagrams are not forwarded);
  - length < 9: drop;
  - `PORT_MATCH_EN` = 1 and destination port ≠ `local_port`: drop;
  - otherwise set `m_udp_hdr_valid` and go to PAYLOAD, loading remaining = length − 8 (16-bit, no wrap possible given the length ≥ 9 check).
- Each drop case pulses `drop`. The tlast-on-byte-7 drop returns to IDLE; the other two go to DROP.

**PAYLOAD**
- Payload beats pass only after the UDP header handshake has completed, i.e. while `m_udp_hdr_valid` = 0.
- Pass-through (combinational, zero latency):
  - tdata = s tdata;
  - tvalid = s tvalid;
  - s tready = m tready.
- Each transfer decrements remaining.
- The beat with remaining = 1 carries tlast = 1 and tuser = s tuser.
  - If the input tlast is not on that beat, go to DROP to discard the IP trailer, without pulsing `drop`.
  - If the input tlast is on that beat, go to IDLE.
- An input tlast with remaining > 1 is forwarded with tlast = 1 and tuser = 1, pulses `error_early_termination`, and returns to IDLE.

**DROP**
- `s_ip_payload_axis_tready` = 1; beats are discarded.
- Go to IDLE on the tlast transfer.

## Timing
- Reset: state IDLE. `m_udp_hdr_valid`, both pulses, all header fields and all counters are 0.
- `s_ip_hdr_ready` is forced to 0 while `rst` is high and is 1 in the first cycle after release.
- Asserting `rst` mid-datagram aborts immediately with no tlast emitted; the upstream remainder arrives later and is treated as a new stream.
- Header latency: IP header accepted in cycle N, header bytes transferred in N+1..N+8 at full rate, `m_udp_hdr_valid` registered high in N+9.
- `m_udp_hdr_valid` is held until `m_udp_hdr_ready` and clears in the cycle after the handshake. The earliest payload transfer is that cycle.
- Header fields are stable while `m_udp_hdr_valid` is high and until the next datagram's byte 0.
- `s_ip_hdr_ready` is low outside IDLE, so there is one datagram in flight.
- Back-to-back datagrams: IDLE lasts at least 1 cycle between them.

## Test plan
- Basic forward: protocol 17, `local_port` = 7400, UDP header 1234/7400/length 12, 4 payload bytes DE AD BE EF with tlast → header fields 1234/7400/12; out bytes DE AD BE EF, tlast on EF, tuser 0; `m_udp_hdr_valid` rises exactly 9 cycles after the IP header handshake.
- Non-UDP: protocol 6, 20-byte payload → `drop` pulses once, all input consumed, no output; next UDP datagram forwarded normally.
- Port mismatch: destination 7401 with `PORT_MATCH_EN` = 1 → dropped. Same stimulus with `PORT_MATCH_EN` = 0 → forwarded.
- Trim: UDP length 10 with 6 input payload bytes (Ethernet padding) → 2 bytes out, tlast on byte 2, remaining 4 bytes discarded, `drop` not pulsed.
- Early end: UDP length 20 with input tlast after 5 payload bytes → 5 bytes out, last one with tlast = 1 and tuser = 1, `error_early_termination` pulses once. Separately, tlast on header byte 3 → `error_early_termination` and `drop` pulse, no output.
- Backpressure and reset: random `m_udp_payload_axis_tready` → byte order and count preserved. `rst` asserted mid-payload → all outputs 0 next cycle, `s_ip_hdr_ready` = 1 after release.

Source files
------------

// File: rtl/udp_rx_parser.sv
// udp_rx_parser
//
// Receive-side UDP stage. It takes the IP header and the IP payload byte
// stream from the IP receive path and keeps only UDP datagrams (protocol 17).
// When PORT_MATCH_EN is set, it also requires the destination port to equal
// local_port. It strips the 8-byte UDP header, presents the header fields on a
// valid/ready header channel, and forwards the payload trimmed to the UDP
// length. Everything else is consumed and discarded.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   s_ip_hdr_*                IP header handshake plus the length, protocol
//                             and address fields
//   s_ip_payload_axis_*       IP payload byte stream (tdata/tvalid/tready/
//                             tlast/tuser)
//   local_port                port filter value; held static while
//                             s_ip_hdr_ready is low
//   m_udp_hdr_*               UDP header handshake plus the latched IP
//                             addresses, ports and UDP length
//   m_udp_payload_axis_*      trimmed UDP payload byte stream
//   error_early_termination   one-cycle pulse when the IP stream ends before
//                             the UDP data does
//   drop                      one-cycle pulse for each discarded datagram
module udp_rx_parser #(
    parameter bit PORT_MATCH_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_ip_hdr_valid,
    output logic        s_ip_hdr_ready,
    input  logic [15:0] s_ip_length,
    input  logic [7:0]  s_ip_protocol,
    input  logic [31:0] s_ip_source_ip,
    input  logic [31:0] s_ip_dest_ip,
    input  logic [7:0]  s_ip_payload_axis_tdata,
    input  logic        s_ip_payload_axis_tvalid,
    output logic        s_ip_payload_axis_tready,
    input  logic        s_ip_payload_axis_tlast,
    input  logic        s_ip_payload_axis_tuser,
    input  logic [15:0] local_port,
    output logic        m_udp_hdr_valid,
    input  logic        m_udp_hdr_ready,
    output logic [31:0] m_udp_source_ip,
    output logic [31:0] m_udp_dest_ip,
    output logic [15:0] m_udp_source_port,
    output logic [15:0] m_udp_dest_port,
    output logic [15:0] m_udp_length,
    output logic [7:0]  m_udp_payload_axis_tdata,
    output logic        m_udp_payload_axis_tvalid,
    input  logic        m_udp_payload_axis_tready,
    output logic        m_udp_payload_axis_tlast,
    output logic        m_udp_payload_axis_tuser,
    output logic        error_early_termination,
    output logic        drop
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [31:0] dst_ip_q, dst_ip_d;
    logic [15:0] src_port_q, src_port_d;
    logic [15:0] dst_port_q, dst_port_d;
    logic [15:0] length_q, length_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic        drop_q, drop_d;
    logic        err_q, err_d;
    logic        pay_xfer;

    // The UDP length field alone decides the datagram size. The IP total
    // length is therefore not needed.
    logic unused_ip_length;
    assign unused_ip_length = ^s_ip_length;

    // The header ready signal is forced low during reset so that no header can
    // be accepted while the state register is held.
    assign s_ip_hdr_ready = (state_q == S_IDLE) && !rst;

    assign m_udp_hdr_valid         = hdr_valid_q;
    assign m_udp_source_ip         = src_ip_q;
    assign m_udp_dest_ip           = dst_ip_q;
    assign m_udp_source_port       = src_port_q;
    assign m_udp_dest_port         = dst_port_q;
    assign m_udp_length            = length_q;
    assign drop                    = drop_q;
    assign error_early_termination = err_q;

    always_comb begin
        // NOTE: every signal written here gets a default first. A path that
        // leaves a signal unassigned would infer a latch.
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        remaining_d = remaining_q;
        src_ip_d    = src_ip_q;
        dst_ip_d    = dst_ip_q;
        src_port_d  = src_port_q;
        dst_port_d  = dst_port_q;
        length_d    = length_q;
        drop_d      = 1'b0;
        err_d       = 1'b0;
        pay_xfer    = 1'b0;
        hdr_valid_d = hdr_valid_q && !m_udp_hdr_ready;

        s_ip_payload_axis_tready  = 1'b0;
        m_udp_payload_axis_tdata  = s_ip_payload_axis_tdata;
        m_udp_payload_axis_tvalid = 1'b0;
        m_udp_payload_axis_tlast  = 1'b0;
        m_udp_payload_axis_tuser  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (s_ip_hdr_valid) begin
                    src_ip_d = s_ip_source_ip;
                    dst_ip_d = s_ip_dest_ip;
                    if (s_ip_protocol == 8'd17) begin
                        hdr_cnt_d = 3'd0;
                        state_d   = S_HEADER;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_DROP;
                    end
                end
            end

            S_HEADER: begin
                s_ip_payload_axis_tready = 1'b1;
                if (s_ip_payload_axis_tvalid) begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    case (hdr_cnt_q)
                        3'd0: src_port_d[15:8] = s_ip_payload_axis_tdata;
                        3'd1: src_port_d[7:0]  = s_ip_payload_axis_tdata;
                        3'd2: dst_port_d[15:8] = s_ip_payload_axis_tdata;
                        3'd3: dst_port_d[7:0]  = s_ip_payload_axis_tdata;
                        3'd4: length_d[15:8]   = s_ip_payload_axis_tdata;
                        3'd5: length_d[7:0]    = s_ip_payload_axis_tdata;
                        default: ;  // checksum bytes are not used
                    endcase
                    if (hdr_cnt_q != 3'd7) begin
                        if (s_ip_payload_axis_tlast) begin
                            err_d   = 1'b1;
                            drop_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (s_ip_payload_axis_tlast) begin
                        // The datagram has no payload, so it is not forwarded.
                        drop_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (length_q < 16'd9) begin
                        drop_d  = 1'b1;
                        state_d = S_DROP;
                    end else if (PORT_MATCH_EN && (dst_port_q != local_port)) begin
                        drop_d  = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        hdr_valid_d = 1'b1;
                        remaining_d = length_q - 16'd8;
                        state_d     = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                // Payload is held back until the header handshake completes.
                m_udp_payload_axis_tvalid = s_ip_payload_axis_tvalid && !hdr_valid_q;
                s_ip_payload_axis_tready  = m_udp_payload_axis_tready && !hdr_valid_q;
                pay_xfer = s_ip_payload_axis_tvalid && m_udp_payload_axis_tready && !hdr_valid_q;
                if (remaining_q == 16'd1) begin
                    m_udp_payload_axis_tlast = 1'b1;
                    m_udp_payload_axis_tuser = s_ip_payload_axis_tuser;
                end else if (s_ip_payload_axis_tlast) begin
                    // The IP stream ended before the UDP length was reached.
                    m_udp_payload_axis_tlast = 1'b1;
                    m_udp_payload_axis_tuser = 1'b1;
                end else begin
                    m_udp_payload_axis_tuser = s_ip_payload_axis_tuser;
                end
                if (pay_xfer) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        // Any bytes after the UDP length are padding and go to
                        // DROP. That path does not pulse drop.
                        state_d = s_ip_payload_axis_tlast ? S_IDLE : S_DROP;
                    end else if (s_ip_payload_axis_tlast) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_DROP: begin
                s_ip_payload_axis_tready = 1'b1;
                if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hdr_cnt_q   <= 3'd0;
            remaining_q <= 16'd0;
            src_ip_q    <= 32'd0;
            dst_ip_q    <= 32'd0;
            src_port_q  <= 16'd0;
            dst_port_q  <= 16'd0;
            length_q    <= 16'd0;
            hdr_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // flop samples its _d value from the same clock edge.
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            remaining_q <= remaining_d;
            src_ip_q    <= src_ip_d;
            dst_ip_q    <= dst_ip_d;
            src_port_q  <= src_port_d;
            dst_port_q  <= dst_port_d;
            length_q    <= length_d;
            hdr_valid_q <= hdr_valid_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Testbench for udp_rx_parser. Two instances are used: one with the port
// filter enabled and one with it disabled. use_nm selects which instance
// receives stimulus and which instance's outputs are observed. Expected
// headers and payload beats come from a small model of the datagram rules.
// They are queued when stimulus is driven and popped by a negedge monitor.
module tb_udp_rx_parser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_ip_hdr_valid;
    logic [15:0] s_ip_length;
    logic [7:0]  s_ip_protocol;
    logic [31:0] s_ip_source_ip, s_ip_dest_ip;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tuser;
    logic [15:0] local_port;
    logic        m_hdr_ready, m_tready;
    logic        use_nm;

    // Per-instance outputs (a: filter on, b: filter off).
    logic        a_hdr_ready, a_tready, a_hdr_valid, a_tvalid, a_tlast, a_tuser, a_err, a_drop;
    logic        b_hdr_ready, b_tready, b_hdr_valid, b_tvalid, b_tlast, b_tuser, b_err, b_drop;
    logic [31:0] a_sip, a_dip, b_sip, b_dip;
    logic [15:0] a_sport, a_dport, a_len, b_sport, b_dport, b_len;
    logic [7:0]  a_tdata, b_tdata;

    // Observed (selected) outputs.
    logic        s_hdr_ready, s_tready, m_hdr_valid, m_tvalid, m_tlast, m_tuser, m_err, m_drop;
    logic [31:0] m_sip, m_dip;
    logic [15:0] m_sport, m_dport, m_len;
    logic [7:0]  m_tdata;

    assign s_hdr_ready = use_nm ? b_hdr_ready : a_hdr_ready;
    assign s_tready    = use_nm ? b_tready    : a_tready;
    assign m_hdr_valid = use_nm ? b_hdr_valid : a_hdr_valid;
    assign m_tvalid    = use_nm ? b_tvalid    : a_tvalid;
    assign m_tlast     = use_nm ? b_tlast     : a_tlast;
    assign m_tuser     = use_nm ? b_tuser     : a_tuser;
    assign m_err       = use_nm ? b_err       : a_err;
    assign m_drop      = use_nm ? b_drop      : a_drop;
    assign m_sip       = use_nm ? b_sip       : a_sip;
    assign m_dip       = use_nm ? b_dip       : a_dip;
    assign m_sport     = use_nm ? b_sport     : a_sport;
    assign m_dport     = use_nm ? b_dport     : a_dport;
    assign m_len       = use_nm ? b_len       : a_len;
    assign m_tdata     = use_nm ? b_tdata     : a_tdata;

    udp_rx_parser dut (
        .clk(clk), .rst(rst),
        .s_ip_hdr_valid(s_ip_hdr_valid & ~use_nm), .s_ip_hdr_ready(a_hdr_ready),
        .s_ip_length(s_ip_length), .s_ip_protocol(s_ip_protocol),
        .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
        .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tvalid(s_tvalid & ~use_nm),
        .s_ip_payload_axis_tready(a_tready), .s_ip_payload_axis_tlast(s_tlast),
        .s_ip_payload_axis_tuser(s_tuser), .local_port(local_port),
        .m_udp_hdr_valid(a_hdr_valid), .m_udp_hdr_ready(m_hdr_ready),
        .m_udp_source_ip(a_sip), .m_udp_dest_ip(a_dip),
        .m_udp_source_port(a_sport), .m_udp_dest_port(a_dport), .m_udp_length(a_len),
        .m_udp_payload_axis_tdata(a_tdata), .m_udp_payload_axis_tvalid(a_tvalid),
        .m_udp_payload_axis_tready(m_tready), .m_udp_payload_axis_tlast(a_tlast),
        .m_udp_payload_axis_tuser(a_tuser),
        .error_early_termination(a_err), .drop(a_drop)
    );

    udp_rx_parser #(.PORT_MATCH_EN(1'b0)) dut_nm (
        .clk(clk), .rst(rst),
        .s_ip_hdr_valid(s_ip_hdr_valid & use_nm), .s_ip_hdr_ready(b_hdr_ready),
        .s_ip_length(s_ip_length), .s_ip_protocol(s_ip_protocol),
        .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
        .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tvalid(s_tvalid & use_nm),
        .s_ip_payload_axis_tready(b_tready), .s_ip_payload_axis_tlast(s_tlast),
        .s_ip_payload_axis_tuser(s_tuser), .local_port(local_port),
        .m_udp_hdr_valid(b_hdr_valid), .m_udp_hdr_ready(m_hdr_ready),
        .m_udp_source_ip(b_sip), .m_udp_dest_ip(b_dip),
        .m_udp_source_port(b_sport), .m_udp_dest_port(b_dport), .m_udp_length(b_len),
        .m_udp_payload_axis_tdata(b_tdata), .m_udp_payload_axis_tvalid(b_tvalid),
        .m_udp_payload_axis_tready(m_tready), .m_udp_payload_axis_tlast(b_tlast),
        .m_udp_payload_axis_tuser(b_tuser),
        .error_early_termination(b_err), .drop(b_drop)
    );

    typedef struct packed {
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [15:0] len;
    } hdr_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    hdr_t       exp_hdr_q[$];
    beat_t      exp_beat_q[$];
    logic [7:0] pay_q[$];

    int errors = 0, checks = 0;
    int cyc = 0, hs_cyc = 0, ip_id = 0;
    int drop_seen = 0, err_seen = 0, exp_drop = 0, exp_err = 0;
    bit lat_check = 0, lat_done = 0, hv_prev = 0, rand_en = 0;
    hdr_t got_hdr, prev_hdr, e_hdr;
    beat_t got_beat, e_beat;

    always @(posedge clk) cyc <= cyc + 1;

    // Output-side ready generation.
    initial begin
        m_tready    = 1'b1;
        m_hdr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready    = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            m_hdr_ready = rand_en ? ($urandom_range(0, 3) == 0) : 1'b1;
        end
    end

    // Scoreboard monitor. It samples on the falling edge, away from the
    // active clock edge.
    always @(negedge clk) begin
        got_hdr  = {m_sip, m_dip, m_sport, m_dport, m_len};
        got_beat = {m_tdata, m_tlast, m_tuser};
        if (m_drop === 1'b1) drop_seen++;
        if (m_err === 1'b1) err_seen++;
        if (m_hdr_valid && !hv_prev && lat_check) begin
            checks++;
            if ((cyc - hs_cyc) !== 9) begin
                errors++;
                $display("FAIL hdr_latency: got %0d cycles, want 9", cyc - hs_cyc);
            end
            lat_done  = 1;
            lat_check = 0;
        end
        if (m_hdr_valid && hv_prev) begin
            checks++;
            if (got_hdr !== prev_hdr) begin
                errors++;
                $display("FAIL hdr_stable: got %h, held %h", got_hdr, prev_hdr);
            end
        end
        if (m_hdr_valid) begin
            checks++;
            if (m_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL payload_gated: tvalid=%b while hdr_valid, want 0", m_tvalid);
            end
        end
        if (m_hdr_valid && m_hdr_ready) begin
            checks++;
            if (exp_hdr_q.size() == 0) begin
                errors++;
                $display("FAIL hdr_unexpected: got %h, want none", got_hdr);
            end else begin
                e_hdr = exp_hdr_q.pop_front();
                if (got_hdr !== e_hdr) begin
                    errors++;
                    $display("FAIL hdr_fields: got %h, want %h", got_hdr, e_hdr);
                end
            end
        end
        if (m_tvalid && m_tready) begin
            checks++;
            if (exp_beat_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got data=%h last=%b user=%b, want none",
                         m_tdata, m_tlast, m_tuser);
            end else begin
                e_beat = exp_beat_q.pop_front();
                if (got_beat !== e_beat) begin
                    errors++;
                    $display("FAIL beat: got data=%h last=%b user=%b, want data=%h last=%b user=%b",
                             got_beat.data, got_beat.last, got_beat.user,
                             e_beat.data, e_beat.last, e_beat.user);
                end
            end
        end
        hv_prev  = m_hdr_valid;
        prev_hdr = got_hdr;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- low-level drivers (start and end at posedge+1) -------
    task automatic ip_hdr(input logic [7:0] proto, input logic [15:0] iplen,
                          input logic [31:0] sip, input logic [31:0] dip);
        int n = 0;
        s_ip_protocol  = proto;
        s_ip_length    = iplen;
        s_ip_source_ip = sip;
        s_ip_dest_ip   = dip;
        s_ip_hdr_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!s_hdr_ready && n < 200);
        checks++;
        if (s_hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ip_hdr_timeout: ready=%b after %0d cycles, want 1", s_hdr_ready, n);
        end else begin
            hs_cyc = cyc;
        end
        @(posedge clk);
        #1;
        s_ip_hdr_valid = 1'b0;
    endtask

    task automatic ip_beat(input logic [7:0] d, input logic last, input logic user);
        int n = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!s_tready && n < 200);
        if (s_tready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: tready=%b after %0d cycles, want 1", s_tready, n);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    // Drives one IP datagram of 'total' payload bytes (UDP header included)
    // and queues whatever the UDP stage is expected to do with it.
    task automatic run_udp(input logic [7:0] proto, input logic [15:0] sport,
                           input logic [15:0] dport, input logic [15:0] ulen,
                           input int total, input logic last_user);
        logic [7:0]  stream[$];
        logic [31:0] sip, dip;
        int          n_pay, rem;
        hdr_t        h;
        beat_t       b;
        ip_id++;
        sip = 32'h0A00_0000 + 32'(ip_id);
        dip = 32'hC0A8_0100 + 32'(ip_id);
        stream = {sport[15:8], sport[7:0], dport[15:8], dport[7:0],
                  ulen[15:8], ulen[7:0], 8'h00, 8'h00};
        foreach (pay_q[i]) stream.push_back(pay_q[i]);
        pay_q.delete();
        for (int i = 0; stream.size() < total; i++) stream.push_back(8'(ip_id * 16 + i));
        while (stream.size() > total) void'(stream.pop_back());

        n_pay = total - 8;
        if (proto != 8'd17) exp_drop++;
        else if (total < 8) begin exp_drop++; exp_err++; end
        else if (total == 8) exp_drop++;
        else if (ulen < 16'd9) exp_drop++;
        else if (!use_nm && dport != local_port) exp_drop++;
        else begin
            h = {sip, dip, sport, dport, ulen};
            exp_hdr_q.push_back(h);
            rem = int'(ulen) - 8;
            if (n_pay >= rem) begin
                for (int k = 0; k < rem; k++) begin
                    b.data = stream[8 + k];
                    b.last = (k == rem - 1);
                    b.user = (k == rem - 1 && k == n_pay - 1) ? last_user : 1'b0;
                    exp_beat_q.push_back(b);
                end
            end else begin
                for (int k = 0; k < n_pay; k++) begin
                    b.data = stream[8 + k];
                    b.last = (k == n_pay - 1);
                    b.user = (k == n_pay - 1);
                    exp_beat_q.push_back(b);
                end
                exp_err++;
            end
        end

        ip_hdr(proto, 16'(20 + total), sip, dip);
        for (int i = 0; i < total; i++)
            ip_beat(stream[i], i == total - 1, (i == total - 1) ? last_user : 1'b0);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_hdr_ready, m_hdr_valid, m_tvalid, s_tready, m_drop, m_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got hdr_ready/hdr_valid/tvalid/tready/drop/err=%b, want 000000",
                     {s_hdr_ready, m_hdr_valid, m_tvalid, s_tready, m_drop, m_err});
        end
        checks++;
        if ({m_sip, m_dip, m_sport, m_dport, m_len} !== 112'd0) begin
            errors++;
            $display("FAIL reset_fields: got %h, want 0", {m_sip, m_dip, m_sport, m_dport, m_len});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, want 1", s_hdr_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        pay_q     = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        lat_done  = 0;
        lat_check = 1;
        run_udp(8'd17, 16'd1234, 16'd7400, 16'd12, 12, 1'b0);
        settle();
        lat_check = 0;
        checks++;
        if (lat_done !== 1'b1) begin
            errors++;
            $display("FAIL basic_hdr_seen: got %b, want 1", lat_done);
        end
        checks++;
        if ({exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen} !== {32'd0, 32'd0, exp_drop, exp_err}) begin
            errors++;
            $display("FAIL basic_counts: got left=%0d/%0d drop=%0d err=%0d, want 0/0 %0d %0d",
                     exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen, exp_drop, exp_err);
        end
    endtask

    task automatic test_non_udp();
        run_udp(8'd6, 16'd80, 16'd7400, 16'd20, 20, 1'b0);
        run_udp(8'd17, 16'd99, 16'd7400, 16'd11, 11, 1'b0);
        settle();
        checks++;
        if ({exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen} !== {32'd0, 32'd0, exp_drop, exp_err}) begin
            errors++;
            $display("FAIL non_udp_counts: got left=%0d/%0d drop=%0d err=%0d, want 0/0 %0d %0d",
                     exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen, exp_drop, exp_err);
        end
    endtask

    task automatic test_port_match();
        run_udp(8'd17, 16'd1234, 16'd7401, 16'd12, 12, 1'b0);
        settle();
        use_nm = 1'b1;
        @(posedge clk);
        #1;
        run_udp(8'd17, 16'd1234, 16'd7401, 16'd12, 12, 1'b0);
        settle();
        use_nm = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen} !== {32'd0, 32'd0, exp_drop, exp_err}) begin
            errors++;
            $display("FAIL port_match_counts: got left=%0d/%0d drop=%0d err=%0d, want 0/0 %0d %0d",
                     exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen, exp_drop, exp_err);
        end
    endtask

    task automatic test_trim_and_bounds();
        run_udp(8'd17, 16'd5, 16'd7400, 16'd10, 14, 1'b0);  // 6 bytes in, 2 out
        run_udp(8'd17, 16'd6, 16'd7400, 16'd9, 9, 1'b1);    // single byte, tuser passes
        run_udp(8'd17, 16'd7, 16'd7400, 16'd8, 8, 1'b0);    // tlast on byte 7
        run_udp(8'd17, 16'd8, 16'd7400, 16'd8, 12, 1'b0);   // length below 9
        settle();
        checks++;
        if ({exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen} !== {32'd0, 32'd0, exp_drop, exp_err}) begin
            errors++;
            $display("FAIL trim_counts: got left=%0d/%0d drop=%0d err=%0d, want 0/0 %0d %0d",
                     exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen, exp_drop, exp_err);
        end
    endtask

    task automatic test_early_end();
        run_udp(8'd17, 16'd9, 16'd7400, 16'd20, 13, 1'b0);  // 5 of 12 payload bytes
        run_udp(8'd17, 16'd10, 16'd7400, 16'd20, 4, 1'b0);  // tlast on header byte 3
        settle();
        checks++;
        if ({exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen} !== {32'd0, 32'd0, exp_drop, exp_err}) begin
            errors++;
            $display("FAIL early_end_counts: got left=%0d/%0d drop=%0d err=%0d, want 0/0 %0d %0d",
                     exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen, exp_drop, exp_err);
        end
    endtask

    task automatic test_backpressure();
        int n;
        rand_en = 1;
        for (int d = 0; d < 6; d++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            run_udp(8'd17, 16'(100 + d), 16'd7400, 16'(8 + n), 8 + n, 1'b0);
        end
        rand_en = 0;
        settle();
        checks++;
        if ({exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen} !== {32'd0, 32'd0, exp_drop, exp_err}) begin
            errors++;
            $display("FAIL backpressure_counts: got left=%0d/%0d drop=%0d err=%0d, want 0/0 %0d %0d",
                     exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen, exp_drop, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        run_udp(8'd17, 16'd1, 16'd7400, 16'd11, 11, 1'b0);
        run_udp(8'd1, 16'd2, 16'd7400, 16'd11, 9, 1'b0);
        run_udp(8'd17, 16'd3, 16'd7400, 16'd10, 10, 1'b0);
        run_udp(8'd17, 16'd4, 16'd7400, 16'd12, 12, 1'b1);
        settle();
        checks++;
        if ({exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen} !== {32'd0, 32'd0, exp_drop, exp_err}) begin
            errors++;
            $display("FAIL back_to_back_counts: got left=%0d/%0d drop=%0d err=%0d, want 0/0 %0d %0d",
                     exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen, exp_drop, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] hb[8] = '{8'h02, 8'h2B, 8'h1C, 8'hE8, 8'h00, 8'h14, 8'h00, 8'h00};
        hdr_t  h;
        beat_t b;
        h = {32'h0A0A_0A0A, 32'h0B0B_0B0B, 16'd555, 16'd7400, 16'd20};
        exp_hdr_q.push_back(h);
        ip_hdr(8'd17, 16'd40, 32'h0A0A_0A0A, 32'h0B0B_0B0B);
        for (int i = 0; i < 8; i++) ip_beat(hb[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            b.data = 8'(8'h30 + i);
            b.last = 1'b0;
            b.user = 1'b0;
            exp_beat_q.push_back(b);
            ip_beat(b.data, 1'b0, 1'b0);
        end
        s_tdata  = 8'h33;
        s_tvalid = 1'b1;
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_hdr_ready, m_hdr_valid, m_tvalid, m_tlast, s_tready, m_drop, m_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b, want 0000000",
                     {s_hdr_ready, m_hdr_valid, m_tvalid, m_tlast, s_tready, m_drop, m_err});
        end
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: got %b, want 1", s_hdr_ready);
        end
        @(posedge clk);
        #1;
        run_udp(8'd17, 16'd77, 16'd7400, 16'd13, 13, 1'b0);
        settle();
        checks++;
        if ({exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen} !== {32'd0, 32'd0, exp_drop, exp_err}) begin
            errors++;
            $display("FAIL reset_mid_counts: got left=%0d/%0d drop=%0d err=%0d, want 0/0 %0d %0d",
                     exp_hdr_q.size(), exp_beat_q.size(), drop_seen, err_seen, exp_drop, exp_err);
        end
    endtask

    initial begin
        rst            = 1'b1;
        use_nm         = 1'b0;
        local_port     = 16'd7400;
        s_ip_hdr_valid = 1'b0;
        s_ip_length    = 16'd0;
        s_ip_protocol  = 8'd0;
        s_ip_source_ip = 32'd0;
        s_ip_dest_ip   = 32'd0;
        s_tdata        = 8'd0;
        s_tvalid       = 1'b0;
        s_tlast        = 1'b0;
        s_tuser        = 1'b0;

        test_reset();
        test_basic();
        test_non_udp();
        test_port_match();
        test_trim_and_bounds();
        test_early_end();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
